// File: rtl/bsg_dmc_dly_calib_ctrl.sv
// bsg_dmc_dly_calib_ctrl: sweeps DQS delay taps, finds each group's first passing window, programs its center.
// Revision 1.0
`default_nettype none

module bsg_dmc_dly_calib_ctrl #(
  parameter int dq_group_p      = 4,
  parameter int tap_width_p     = 6,
  parameter int settle_cycles_p = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              start_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              tap_v_o,
  input  logic                              tap_ready_i,
  output logic [dq_group_p*tap_width_p-1:0] tap_o,
  output logic                              train_v_o,
  input  logic                              train_ready_i,
  input  logic                              result_v_i,
  input  logic [dq_group_p-1:0]             result_pass_i,
  output logic [dq_group_p-1:0]             window_valid_o
);

  localparam int cnt_w_lp = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
  localparam logic [cnt_w_lp-1:0] settle_init_lp = cnt_w_lp'(settle_cycles_p - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SET_TAP  = 3'd1;
  localparam logic [2:0] SETTLE   = 3'd2;
  localparam logic [2:0] TRAIN    = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] CENTER   = 3'd5;
  localparam logic [2:0] APPLY    = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  logic [2:0]                             state_q, state_d;
  logic [tap_width_p-1:0]                 sweep_q, sweep_d;
  logic [cnt_w_lp-1:0]                    cnt_q, cnt_d;
  logic [dq_group_p-1:0][tap_width_p-1:0] tap_q, tap_d;
  logic [dq_group_p-1:0]                  found_q, found_d;
  logic [dq_group_p-1:0]                  closed_q, closed_d;
  logic [dq_group_p-1:0][tap_width_p-1:0] first_q, first_d;
  logic [dq_group_p-1:0][tap_width_p-1:0] last_q, last_d;
  logic [dq_group_p-1:0]                  window_valid_q, window_valid_d;

  logic [tap_width_p-1:0]                 sweep_inc;
  logic [dq_group_p-1:0][tap_width_p-1:0] center_tap;

  assign sweep_inc = sweep_q + tap_width_p'(1);

  // Sum is one bit wider than a tap so first+last never wraps before halving.
  for (genvar g = 0; g < dq_group_p; g++) begin : g_center
    logic [tap_width_p:0] sum;
    assign sum           = {1'b0, first_q[g]} + {1'b0, last_q[g]};
    assign center_tap[g] = tap_width_p'(sum >> 1);
  end

  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    cnt_d          = cnt_q;
    tap_d          = tap_q;
    found_d        = found_q;
    closed_d       = closed_q;
    first_d        = first_q;
    last_d         = last_q;
    window_valid_d = window_valid_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d        = SET_TAP;
          sweep_d        = '0;
          tap_d          = '0;
          found_d        = '0;
          closed_d       = '0;
          first_d        = '0;
          last_d         = '0;
          window_valid_d = '0;
        end
      end

      SET_TAP: begin
        if (tap_ready_i) begin
          state_d = SETTLE;
          cnt_d   = settle_init_lp;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) state_d = TRAIN;
        else             cnt_d   = cnt_q - cnt_w_lp'(1);
      end

      TRAIN: begin
        if (train_ready_i) state_d = WAIT_RES;
      end

      WAIT_RES: begin
        if (result_v_i) begin
          // Only the first contiguous passing run per group is kept.
          for (int g = 0; g < dq_group_p; g++) begin
            if (result_pass_i[g] && !found_q[g]) begin
              found_d[g] = 1'b1;
              first_d[g] = sweep_q;
              last_d[g]  = sweep_q;
            end else if (result_pass_i[g] && !closed_q[g]) begin
              last_d[g]  = sweep_q;
            end else if (!result_pass_i[g] && found_q[g]) begin
              closed_d[g] = 1'b1;
            end
          end
          if (sweep_q == '1) begin
            state_d = CENTER;
          end else begin
            state_d = SET_TAP;
            sweep_d = sweep_inc;
            for (int g = 0; g < dq_group_p; g++) tap_d[g] = sweep_inc;
          end
        end
      end

      CENTER: begin
        state_d = APPLY;
        for (int g = 0; g < dq_group_p; g++) begin
          tap_d[g]          = found_q[g] ? center_tap[g] : '0;
          window_valid_d[g] = found_q[g];
        end
      end

      APPLY: begin
        if (tap_ready_i) state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      sweep_q        <= '0;
      cnt_q          <= '0;
      tap_q          <= '0;
      found_q        <= '0;
      closed_q       <= '0;
      first_q        <= '0;
      last_q         <= '0;
      window_valid_q <= '0;
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      cnt_q          <= cnt_d;
      tap_q          <= tap_d;
      found_q        <= found_d;
      closed_q       <= closed_d;
      first_q        <= first_d;
      last_q         <= last_d;
      window_valid_q <= window_valid_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign tap_v_o        = (state_q == SET_TAP) || (state_q == APPLY);
  assign train_v_o      = (state_q == TRAIN);
  assign tap_o          = tap_q;
  assign window_valid_o = window_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_dmc_dly_calib_ctrl.sv
// Directed and randomized bench for bsg_dmc_dly_calib_ctrl against a window-scan reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_bsg_dmc_dly_calib_ctrl;

  localparam int G  = 4;
  localparam int W  = 3;
  localparam int S  = 4;
  localparam int NT = 1 << W;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic           start_i;
  logic           busy_o;
  logic           done_o;
  logic           tap_v_o;
  logic           tap_ready_i;
  logic [G*W-1:0] tap_o;
  logic           train_v_o;
  logic           train_ready_i;
  logic           result_v_i;
  logic [G-1:0]   result_pass_i;
  logic [G-1:0]   window_valid_o;

  bsg_dmc_dly_calib_ctrl #(
    .dq_group_p(G), .tap_width_p(W), .settle_cycles_p(S)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .tap_v_o(tap_v_o), .tap_ready_i(tap_ready_i), .tap_o(tap_o),
    .train_v_o(train_v_o), .train_ready_i(train_ready_i), .result_v_i(result_v_i),
    .result_pass_i(result_pass_i), .window_valid_o(window_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [G-1:0] tbl [NT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: locate the first passing tap, extend while consecutive taps pass, take the rounded-down midpoint.
  task automatic model(output logic [G*W-1:0] taps, output logic [G-1:0] wv);
    taps = '0;
    wv   = '0;
    for (int g = 0; g < G; g++) begin
      int f;
      int e;
      f = -1;
      for (int t = 0; t < NT; t++) if (f < 0 && tbl[t][g]) f = t;
      if (f >= 0) begin
        e = f;
        while (e + 1 < NT && tbl[e+1][g]) e++;
        taps[g*W +: W] = W'((f + e) / 2);
        wv[g]          = 1'b1;
      end
    end
  endtask

  function automatic logic [G*W-1:0] rep(input int t);
    logic [W-1:0]   tv;
    logic [G*W-1:0] r;
    tv = W'(t);
    for (int g = 0; g < G; g++) r[g*W +: W] = tv;
    return r;
  endfunction

  // One calibration run. tw/rw: ready stall cycles; inject: spurious start/result pulses; stop_at: reset during that tap's settle.
  task automatic run(input int tw, input int rw, input bit inject, input int stop_at);
    logic [G*W-1:0] exp_taps;
    logic [G-1:0]   exp_wv;
    int             n;
    model(exp_taps, exp_wv);
    check("idle_busy", busy_o, 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("wv_cleared", window_valid_o, 0);
    for (int t = 0; t < NT; t++) begin
      n = 0;
      while (!tap_v_o && n < 50) begin step(); n++; end
      check("tap_v_sweep", tap_v_o, 1);
      check("tap_sweep_val", tap_o, rep(t));
      for (int k = 0; k < tw; k++) begin
        step();
        check("tap_v_hold", tap_v_o, 1);
        check("tap_o_hold", tap_o, rep(t));
      end
      tap_ready_i = 1'b1;
      step();
      tap_ready_i = 1'b0;
      check("tap_v_drop", tap_v_o, 0);
      if (t == stop_at) begin
        step();
        reset_n_i = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_tap_v", tap_v_o, 0);
        check("rst_train_v", train_v_o, 0);
        check("rst_tap_o", tap_o, 0);
        check("rst_wv", window_valid_o, 0);
        check("rst_done", done_o, 0);
        step();
        reset_n_i = 1'b1;
        step();
        return;
      end
      n = 0;
      if (inject) begin
        start_i       = 1'b1;
        result_v_i    = 1'b1;
        result_pass_i = ~tbl[t];
        step();
        n++;
        start_i    = 1'b0;
        result_v_i = 1'b0;
      end
      while (!train_v_o && n < 50) begin step(); n++; end
      check("settle_len", n, S);
      for (int k = 0; k < rw; k++) begin
        step();
        check("train_v_hold", train_v_o, 1);
      end
      train_ready_i = 1'b1;
      if (inject) begin
        result_v_i    = 1'b1;
        result_pass_i = ~tbl[t];
      end
      step();
      train_ready_i = 1'b0;
      result_v_i    = 1'b0;
      check("train_v_drop", train_v_o, 0);
      repeat ($urandom_range(0, 2)) step();
      result_v_i    = 1'b1;
      result_pass_i = tbl[t];
      step();
      result_v_i = 1'b0;
    end
    n = 0;
    while (!tap_v_o && n < 50) begin step(); n++; end
    check("apply_tap_v", tap_v_o, 1);
    check("apply_taps", tap_o, exp_taps);
    check("apply_wv", window_valid_o, exp_wv);
    for (int k = 0; k < tw; k++) begin
      step();
      check("apply_hold", tap_o, exp_taps);
    end
    tap_ready_i = 1'b1;
    step();
    tap_ready_i = 1'b0;
    check("done_pulse", done_o, 1);
    step();
    check("done_clear", done_o, 0);
    check("end_busy", busy_o, 0);
    check("end_taps", tap_o, exp_taps);
    check("end_wv", window_valid_o, exp_wv);
  endtask

  initial begin
    reset_n_i     = 1'b0;
    start_i       = 1'b0;
    tap_ready_i   = 1'b0;
    train_ready_i = 1'b0;
    result_v_i    = 1'b0;
    result_pass_i = '0;
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_tap_v", tap_v_o, 0);
    check("reset_train_v", train_v_o, 0);
    check("reset_tap_o", tap_o, 0);
    check("reset_wv", window_valid_o, 0);
    check("reset_done", done_o, 0);
    step();
    step();
    reset_n_i = 1'b1;
    step();

    // Group0 passes 2..5, others pass everywhere.
    for (int t = 0; t < NT; t++) tbl[t] = {3'b111, (t >= 2 && t <= 5)};
    run(0, 0, 1'b0, -1);
    check("s1_taps", tap_o, {3'd3, 3'd3, 3'd3, 3'd3});
    check("s1_wv", window_valid_o, 4'b1111);
    run(5, 5, 1'b0, -1);
    check("s1_stall_taps", tap_o, {3'd3, 3'd3, 3'd3, 3'd3});

    // Group1 has a second window that must be ignored, group2 never passes.
    for (int t = 0; t < NT; t++) begin
      tbl[t][0] = (t >= 2 && t <= 5);
      tbl[t][1] = (t == 1 || t == 2 || t == 6 || t == 7);
      tbl[t][2] = 1'b0;
      tbl[t][3] = 1'b1;
    end
    run(0, 0, 1'b0, -1);
    check("s2_taps", tap_o, {3'd3, 3'd0, 3'd1, 3'd3});
    check("s2_wv", window_valid_o, 4'b1011);
    run(1, 2, 1'b1, -1);
    check("s2_inject_taps", tap_o, {3'd3, 3'd0, 3'd1, 3'd3});

    run(0, 0, 1'b0, 4);
    run(0, 0, 1'b0, -1);
    check("post_rst_taps", tap_o, {3'd3, 3'd0, 3'd1, 3'd3});

    for (int r = 0; r < 4; r++) begin
      for (int t = 0; t < NT; t++) tbl[t] = G'($urandom);
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
